_serial_tx: RTL

Parallel-in, serial-out framed transmitter. Accepts a WIDTH-bit word over a valid/ready handshake and shifts it out on a single line: start bit (0), data LSB-first, stop bit (1). Each bit is held for CLKS_PER_BIT clocks. It pairs with the team's serial receiver and sits between a word-level producer and the serial pin.

---
 rtl/_serial_tx_pkg.sv | 20 ++
 rtl/_serial_tx_shift_reg.sv | 38 +++
 rtl/_serial_tx.sv | 128 ++++++++++++
 3 files changed

// File: rtl/_serial_tx_pkg.sv
// Shared definitions for the framed serial transmitter: state encoding,
// line-level framing constants and a counter-sizing helper.
package _serial_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_START = 2'b01,
    ST_DATA  = 2'b10,
    ST_STOP  = 2'b11
  } tx_state_e;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // Counter width for values 0..n-1, never narrower than one bit.
  function automatic int min1_clog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/_serial_tx_shift_reg.sv
// WIDTH-bit shift-right register: synchronous active-low clear, parallel load,
// shift enable. Clear beats load, load beats shift. Presents its LSB.
module _shift_reg_n #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] d,
  output logic             lsb
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = d;
    end else if (shift) begin
      q_d = q_q >> 1;
    end else begin
      q_d = q_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign lsb = q_q[0];

endmodule

// File: rtl/_serial_tx.sv
// Parallel-in, serial-out framed transmitter: start bit, WIDTH data bits
// LSB-first, stop bit, each held CLKS_PER_BIT clocks. tx is registered.
module _serial_tx
  import _serial_tx_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] din,
  input  logic             valid,
  output logic             ready,
  output logic             tx,
  output logic             busy
);

  localparam int CNT_W = min1_clog2(CLKS_PER_BIT);
  localparam int IDX_W = min1_clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

  tx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             tx_q, tx_d;
  logic             load_s;
  logic             shift_s;
  logic             bit_wrap_s;
  logic             shreg_lsb_s;

  _shift_reg_n #(.WIDTH(WIDTH)) u_shreg (
    .clk   (clk),
    .clr_n (reset_n),
    .load  (load_s),
    .shift (shift_s),
    .d     (din),
    .lsb   (shreg_lsb_s)
  );

  assign bit_wrap_s = (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    load_s  = 1'b0;
    shift_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (valid) begin
          state_d = ST_START;
          cnt_d   = '0;
          idx_d   = '0;
          load_s  = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (bit_wrap_s) begin
          cnt_d   = '0;
          state_d = ST_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DATA: begin
        // The shift happens on the wrap; tx_d below still sees the old LSB.
        if (bit_wrap_s) begin
          cnt_d   = '0;
          shift_s = 1'b1;
          idx_d   = idx_q + IDX_W'(1);
          if (idx_q == IDX_LAST) begin
            state_d = ST_STOP;
          end else begin
            state_d = ST_DATA;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_STOP: begin
        if (bit_wrap_s) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase
  end

  always_comb begin
    tx_d = STOP_BIT;
    case (state_q)
      ST_IDLE:  tx_d = STOP_BIT;
      ST_START: tx_d = START_BIT;
      ST_DATA:  tx_d = shreg_lsb_s;
      ST_STOP:  tx_d = STOP_BIT;
      default:  tx_d = STOP_BIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      tx_q    <= STOP_BIT;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
    end
  end

  assign ready = (state_q == ST_IDLE);
  assign busy  = ~ready;
  assign tx    = tx_q;

endmodule
